// File: rtl/alu_regfile_seq.sv
// Operand sequencer + 32x32 register file feeding a combinational ALU (IDLE/READ/EXEC/WB).
// Optional feature macro: ALU_FLAGS_EN (zero/overflow flag registers); flags tie to 0 when undefined.
module alu_regfile_seq #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    rs_addr,
  input  logic [4:0]    rt_addr,
  input  logic [4:0]    rd_addr,
  input  logic [2:0]    op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_f,
  output logic [DW-1:0] result,
  output logic          zf,
  output logic          of,
  output logic          done,
  input  logic [4:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [2:0] op;
  } req_t;

  state_t          state, state_nxt;
  req_t            req;
  logic [DW-1:0]   rf [NREG];
  logic [DW-1:0]   rs_val, rt_val;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // r0 is hardwired to zero on every read port
  assign rs_val   = (req.rs == 5'd0)   ? '0 : rf[req.rs];
  assign rt_val   = (req.rt == 5'd0)   ? '0 : rf[req.rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      req    <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req.rs <= rs_addr;
          req.rt <= rt_addr;
          req.rd <= rd_addr;
          req.op <= op;
        end
        READ: begin
          alu_a  <= rs_val;
          alu_b  <= rt_val;
          alu_op <= req.op;
        end
        EXEC: result <= alu_f;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state == WB && req.rd != 5'd0) begin
      rf[req.rd] <= result;
    end
  end

`ifdef ALU_FLAGS_EN
  logic of_nxt;

  // alu_a/alu_b still hold this op's operands during WB
  always_comb begin
    of_nxt = 1'b0;
    case (alu_op)
      3'b100: of_nxt = (alu_a[DW-1] == alu_b[DW-1]) && (result[DW-1] != alu_a[DW-1]);
      3'b101: of_nxt = (alu_a[DW-1] != alu_b[DW-1]) && (result[DW-1] != alu_a[DW-1]);
      default: of_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
      of <= 1'b0;
    end else if (state == WB) begin
      zf <= (result == '0);
      of <= of_nxt;
    end
  end
`else
  assign zf = 1'b0;
  assign of = 1'b0;
`endif

endmodule
